// File: rtl/multicycle_addsub_if.sv
// Request/response bundle for multicycle_addsub.
//   master: requester/consumer side (in_valid, a, b, op, acc_clr, out_ready out)
//   slave : the adder block (in_ready, out_valid, s, cout, ovf, zero out)
interface multicycle_addsub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, op, acc_clr, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, op, acc_clr, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );
endinterface

// File: rtl/multicycle_addsub.sv
// Digit-serial two's-complement add/subtract with accumulator.
// A WIDTH-bit operation is processed DIGIT bits per cycle over N = WIDTH/DIGIT
// cycles. op: 00 A+B, 01 A-B, 10 ACC+B, 11 ACC-B.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of multicycle_addsub_if (request in, result out)
module multicycle_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_addsub_if.slave bus
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = DIGIT + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] s_q;
  logic             acc_op;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  int unsigned      base_c;
  logic [DIGIT-1:0] sa_c;
  logic [DIGIT-1:0] sb_c;
  logic [SW-1:0]    sum_c;
  logic             cmsb_c;
  logic             last_c;
  logic [WIDTH-1:0] res_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_c)        state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Current slice sum; res_c is the result register with this slice merged in
  always_comb begin
    base_c = 32'(cnt) * DIGIT;
    sa_c   = opa[base_c +: DIGIT];
    sb_c   = opb[base_c +: DIGIT];
    sum_c  = SW'(sa_c) + SW'(sb_c) + SW'(carry);
    // carry into the slice MSB recovered from the MSB sum bit
    cmsb_c = sum_c[DIGIT-1] ^ sa_c[DIGIT-1] ^ sb_c[DIGIT-1];
    last_c = (cnt == CW'(N - 1));
    res_c  = s_q;
    res_c[base_c +: DIGIT] = sum_c[DIGIT-1:0];
  end

  // Operand latch, slice datapath, accumulator and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      s_q    <= '0;
      acc_op <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.acc_clr) acc <= '0;
          if (bus.in_valid) begin
            // a clear on the accept edge wins over the old accumulator value
            if (!bus.op[1])       opa <= bus.a;
            else if (bus.acc_clr) opa <= '0;
            else                  opa <= acc;
            opb    <= bus.b ^ {WIDTH{bus.op[0]}};
            carry  <= bus.op[0];
            cnt    <= '0;
            acc_op <= bus.op[1];
          end
        end
        RUN: begin
          s_q   <= res_c;
          carry <= sum_c[DIGIT];
          if (last_c) begin
            cout_q <= sum_c[DIGIT];
            ovf_q  <= cmsb_c ^ sum_c[DIGIT];
            zero_q <= (res_c == '0);
            if (acc_op) acc <= res_c;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Bench for multicycle_addsub: directed cases on a 16/4 instance plus
// randomized traffic on 8/8 and 32/4 instances against an arithmetic model.
module tb_multicycle_addsub;

  logic clk;
  logic rst_n;
  logic rst_r;
  int   n_checks;
  int   n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- directed instance, WIDTH=16 DIGIT=4 ----------------
  multicycle_addsub_if #(.WIDTH(16)) bus0 ();
  multicycle_addsub #(.WIDTH(16), .DIGIT(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic [1:0] iop, input logic clr, input logic [15:0] es,
                        input logic ec, input logic ev, input logic ez,
                        input int stall, input logic clr_run);
    int k;
    @(negedge clk);
    bus0.a = ia; bus0.b = ib; bus0.op = iop; bus0.acc_clr = clr;
    bus0.in_valid = 1'b1; bus0.out_ready = 1'b0;
    k = 0;
    while (!bus0.in_ready && k < 20) begin @(negedge clk); k++; end
    check({tag, " in_ready"}, 64'(bus0.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    bus0.acc_clr  = clr_run;
    k = 0;
    while (!bus0.out_valid && k < 40) begin
      @(posedge clk); k++;
      @(negedge clk); bus0.acc_clr = 1'b0;
    end
    bus0.acc_clr = 1'b0;
    check({tag, " latency"}, 64'(k), 64'd4);
    check({tag, " s"},    64'(bus0.s),    64'(es));
    check({tag, " cout"}, 64'(bus0.cout), 64'(ec));
    check({tag, " ovf"},  64'(bus0.ovf),  64'(ev));
    check({tag, " zero"}, 64'(bus0.zero), 64'(ez));
    repeat (stall) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold out_valid"}, 64'(bus0.out_valid), 64'd1);
      check({tag, " hold in_ready"},  64'(bus0.in_ready),  64'd0);
      check({tag, " hold s"},    64'(bus0.s),    64'(es));
      check({tag, " hold flags"}, 64'({bus0.cout, bus0.ovf, bus0.zero}), 64'({ec, ev, ez}));
    end
    bus0.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.out_ready = 1'b0;
    check({tag, " out_valid drop"}, 64'(bus0.out_valid), 64'd0);
    check({tag, " in_ready back"},  64'(bus0.in_ready),  64'd1);
  endtask

  // ---------------- randomized instances ----------------
  for (genvar g = 0; g < 2; g++) begin : rnd
    localparam int unsigned W = (g == 0) ? 8 : 32;
    localparam int unsigned D = (g == 0) ? 8 : 4;
    localparam int unsigned N = W / D;

    bit done;

    multicycle_addsub_if #(.WIDTH(W)) bus ();
    multicycle_addsub #(.WIDTH(W), .DIGIT(D)) dut (.clk(clk), .rst_n(rst_r), .bus(bus));

    function automatic longint unsigned pick(input longint unsigned mask);
      case ($urandom_range(0, 5))
        0:       return 64'd0;
        1:       return mask;
        2:       return 64'd1 << (W - 1);
        3:       return (64'd1 << (W - 1)) - 64'd1;
        default: return ({32'($urandom), 32'($urandom)}) & mask;
      endcase
    endfunction

    initial begin : engine
      longint unsigned mask, acc_m, ra, rb, opa, res, e, acc_edge;
      logic [1:0] rop;
      logic busy, have_req, req_up, seen, ec, ev, ez;
      longint unsigned es;
      int ops;
      mask = (64'd1 << W) - 64'd1;
      done = 1'b0;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
      bus.acc_clr = 1'b0; bus.out_ready = 1'b0;
      while (!rst_r) @(negedge clk);
      @(negedge clk);
      acc_m = 0; busy = 0; have_req = 0; req_up = 0; seen = 0;
      e = 0; acc_edge = 0; ops = 0; ra = 0; rb = 0; rop = 0;
      es = 0; ec = 0; ev = 0; ez = 0;
      while (ops < 1000 && e < 60000) begin
        if (!have_req) begin
          ra = pick(mask); rb = pick(mask); rop = 2'($urandom_range(0, 3));
          have_req = 1;
        end
        bus.a  = W'(ra);
        bus.b  = W'(rb);
        bus.op = rop;
        bus.in_valid  = have_req && (req_up || $urandom_range(0, 3) != 0);
        req_up        = bus.in_valid;
        bus.acc_clr   = ($urandom_range(0, 9) == 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
        // model of the coming edge
        if (!busy) begin
          if (bus.acc_clr) acc_m = 0;
          if (bus.in_valid) begin
            opa = rop[1] ? acc_m : ra;
            if (rop[0]) begin
              res = (opa - rb) & mask;
              ec  = (opa >= rb);
              ev  = (opa[W-1] != rb[W-1]) && (res[W-1] != opa[W-1]);
            end else begin
              res = (opa + rb) & mask;
              ec  = (((opa + rb) >> W) & 64'd1) != 0;
              ev  = (opa[W-1] == rb[W-1]) && (res[W-1] != opa[W-1]);
            end
            es = res;
            ez = (res == 0);
            if (rop[1]) acc_m = res;
            busy = 1; acc_edge = e + 1; have_req = 0; req_up = 0; seen = 0;
          end
        end else if (e - acc_edge >= N && bus.out_ready) begin
          busy = 0;
          ops++;
        end
        @(negedge clk);
        e++;
        check($sformatf("w%0d in_ready", W), 64'(bus.in_ready), 64'(!busy));
        check($sformatf("w%0d out_valid", W), 64'(bus.out_valid),
              64'(busy && (e - acc_edge >= N)));
        if (bus.out_valid) begin
          if (!seen) begin
            seen = 1;
            check($sformatf("w%0d latency", W), e - acc_edge, 64'(N));
          end
          check($sformatf("w%0d s", W), 64'(bus.s), es);
          check($sformatf("w%0d cout", W), 64'(bus.cout), 64'(ec));
          check($sformatf("w%0d ovf", W), 64'(bus.ovf), 64'(ev));
          check($sformatf("w%0d zero", W), 64'(bus.zero), 64'(ez));
        end
      end
      check($sformatf("w%0d ops completed", W), 64'(ops), 64'd1000);
      bus.in_valid = 1'b0;
      done = 1'b1;
    end
  end

  initial begin
    rst_r = 1'b0;
    repeat (3) @(negedge clk);
    rst_r = 1'b1;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.op = '0;
    bus0.acc_clr = 1'b0; bus0.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset in_ready",  64'(bus0.in_ready),  64'd1);
    check("reset out_valid", 64'(bus0.out_valid), 64'd0);
    check("reset s",         64'(bus0.s),         64'd0);
    check("reset flags",     64'({bus0.cout, bus0.ovf, bus0.zero}), 64'd0);
    rst_n = 1'b1;

    run_op("add",      16'h0003, 16'h0002, 2'b00, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op("sub",      16'h000C, 16'h0005, 2'b01, 1'b0, 16'h0007, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_op("sub neg",  16'h0003, 16'h0005, 2'b01, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op("ovf add",  16'h7FFF, 16'h0001, 2'b00, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    run_op("ovf sub",  16'h8000, 16'h0001, 2'b01, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    run_op("wrap0",    16'hFFFF, 16'h0001, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    run_op("acc pre",  16'h1111, 16'h0007, 2'b10, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op("acc clr",  16'h2222, 16'h0010, 2'b10, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op("acc 2",    16'h0000, 16'h0010, 2'b10, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op("acc 3",    16'h0000, 16'h0010, 2'b10, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op("acc sub",  16'h0000, 16'h0030, 2'b11, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    run_op("clr run",  16'h0000, 16'h0005, 2'b10, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_op("acc keep", 16'h0000, 16'h0001, 2'b10, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op("backpres", 16'hFFFF, 16'h0001, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 5, 1'b0);

    // reset during the second RUN cycle
    @(negedge clk);
    bus0.a = 16'h0010; bus0.b = 16'h0011; bus0.op = 2'b00; bus0.in_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrun in_ready",  64'(bus0.in_ready),  64'd1);
    check("midrun out_valid", 64'(bus0.out_valid), 64'd0);
    check("midrun s",         64'(bus0.s),         64'd0);
    check("midrun flags",     64'({bus0.cout, bus0.ovf, bus0.zero}), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("midrun no out_valid", 64'(bus0.out_valid), 64'd0);
    end
    rst_n = 1'b1;

    run_op("post rst", 16'h1234, 16'h1111, 2'b00, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op("acc rst",  16'hAAAA, 16'h0000, 2'b10, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 1'b0);

    k = 0;
    while (!(rnd[0].done && rnd[1].done) && k < 90000) begin
      @(negedge clk);
      k++;
    end
    check("random engines finished", 64'(rnd[0].done && rnd[1].done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
